// File: rtl/ctrl_pipe_v.sv
// ctrl_pipe_v
// Carries a decoded control word from D through the E, M and W stages of an
// in-order pipeline that has a multi-beat vector execute stage.
//
// A scalar instruction spends one cycle in E. A vector instruction spends
// BEATS = VLANES/LPC cycles in E, one beat per cycle. Each beat then moves
// through M and W on its own, so M and W see one entry per beat. While E still
// has beats left to issue, stall_o holds F/D.
//
// Parameters
//   CW      control-word width
//   VLANES  elements per vector operation
//   LPC     lanes processed per cycle (VLANES must be a multiple of LPC)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   ctrl_d       decoded control word from D
//   valid_d      D holds a real instruction
//   vec_d        D instruction is a vector op
//   stall_in     hazard-unit stall: D holds and a bubble enters E
//   flush_e      hazard-unit flush: a bubble enters E and any op in E is aborted
//   ctrl_e/m/w   control word in E, M, W
//   valid_e/m/w  stage holds a real beat
//   beat_e/m/w   beat index of the op in that stage
//   last_beat_e  E holds the final beat of its op
//   stall_o      E still has vector beats to issue, so F/D must hold

module ctrl_pipe_v #(
  parameter  int CW     = 16,
  parameter  int VLANES = 8,
  parameter  int LPC    = 2,
  localparam int BEATS  = VLANES / LPC,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] ctrl_d,
  input  logic          valid_d,
  input  logic          vec_d,
  input  logic          stall_in,
  input  logic          flush_e,
  output logic [CW-1:0] ctrl_e,
  output logic [CW-1:0] ctrl_m,
  output logic [CW-1:0] ctrl_w,
  output logic          valid_e,
  output logic          valid_m,
  output logic          valid_w,
  output logic [BW-1:0] beat_e,
  output logic [BW-1:0] beat_m,
  output logic [BW-1:0] beat_w,
  output logic          last_beat_e,
  output logic          stall_o
);

  // Index of the final beat. With BEATS == 1 this is 0, so every op is on its
  // last beat as soon as it enters E and vector ops behave exactly like scalars.
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // E-stage state. The vec flag is internal; it only affects how long the op
  // stays in E.
  logic [CW-1:0] ctrlE_q, ctrlE_d;
  logic          validE_q, validE_d;
  logic          vecE_q, vecE_d;
  logic [BW-1:0] beatE_q, beatE_d;

  // M and W simply shadow the stage in front of them one cycle later.
  logic [CW-1:0] ctrlM_q, ctrlW_q;
  logic          validM_q, validW_q;
  logic [BW-1:0] beatM_q, beatW_q;

  // A vector op keeps E busy until its last beat has been issued. The op
  // leaves E on that last beat, so the beat counter never has to wrap.
  assign stall_o     = validE_q & vecE_q & (beatE_q != LAST_BEAT);
  assign last_beat_e = validE_q & (~vecE_q | (beatE_q == LAST_BEAT));

  // Next E contents. A flush wins over everything except reset: it discards
  // the remaining beats and drops the D instruction of that cycle. While E is
  // still issuing beats, the D inputs and stall_in are ignored and only the beat
  // index moves. Otherwise a stall or an empty D produces a bubble, and a real
  // D instruction starts at beat 0. Reset is applied in the register block
  // below so that it overrides all of these cases.
  always_comb begin
    ctrlE_d  = ctrlE_q;
    validE_d = validE_q;
    vecE_d   = vecE_q;
    beatE_d  = beatE_q;
    if (flush_e) begin
      ctrlE_d  = '0;
      validE_d = 1'b0;
      vecE_d   = 1'b0;
      beatE_d  = '0;
    end else if (stall_o) begin
      beatE_d  = beatE_q + BW'(1);
    end else if (stall_in || !valid_d) begin
      ctrlE_d  = '0;
      validE_d = 1'b0;
      vecE_d   = 1'b0;
      beatE_d  = '0;
    end else begin
      ctrlE_d  = ctrl_d;
      validE_d = 1'b1;
      vecE_d   = vec_d;
      beatE_d  = '0;
    end
  end

  // Pipeline registers. Reset turns every stage into a bubble, which also
  // abandons any vector op that is part-way through E. M and W never stall
  // or flush: a beat that has already left E always completes through W.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlE_q  <= '0;
      validE_q <= 1'b0;
      vecE_q   <= 1'b0;
      beatE_q  <= '0;
      ctrlM_q  <= '0;
      validM_q <= 1'b0;
      beatM_q  <= '0;
      ctrlW_q  <= '0;
      validW_q <= 1'b0;
      beatW_q  <= '0;
    end else begin
      ctrlE_q  <= ctrlE_d;
      validE_q <= validE_d;
      vecE_q   <= vecE_d;
      beatE_q  <= beatE_d;
      ctrlM_q  <= ctrlE_q;
      validM_q <= validE_q;
      beatM_q  <= beatE_q;
      ctrlW_q  <= ctrlM_q;
      validW_q <= validM_q;
      beatW_q  <= beatM_q;
    end
  end

  assign ctrl_e  = ctrlE_q;
  assign valid_e = validE_q;
  assign beat_e  = beatE_q;
  assign ctrl_m  = ctrlM_q;
  assign valid_m = validM_q;
  assign beat_m  = beatM_q;
  assign ctrl_w  = ctrlW_q;
  assign valid_w = validW_q;
  assign beat_w  = beatW_q;

endmodule

// File: doc/ctrl_pipe_v.md
CTRL_PIPE_V -- requirements
Module: ctrl_pipe_v

Interface
REQ-001 Parameter CW, default 16: control-word width carried from D to W.
REQ-002 Parameter VLANES, default 8: elements per vector operation.
REQ-003 Parameter LPC, default 2: lanes processed per cycle; BEATS = VLANES/LPC; BW = max(1, clog2(BEATS)).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ctrl_d  in  CW  decoded control word from D stage.
REQ-007 valid_d  in  1  ctrl_d holds a real instruction.
REQ-008 vec_d  in  1  D instruction is a vector op (multi-beat in E).
REQ-009 stall_in  in  1  hazard-unit stall; D holds, bubble enters E.
REQ-010 flush_e  in  1  hazard-unit flush; bubble enters E, aborting any op in E.
REQ-011 ctrl_e, ctrl_m, ctrl_w  out  CW each  control word in E, M, W.
REQ-012 valid_e, valid_m, valid_w  out  1 each  stage holds a real beat.
REQ-013 beat_e, beat_m, beat_w  out  BW each  beat index of the op in that stage.
REQ-014 last_beat_e  out  1  E holds the final beat of its op.
REQ-015 stall_o  out  1  E busy with remaining vector beats; F/D must hold.

Function
REQ-016 Parameter legality: VLANES mod LPC SHALL be 0 and LPC >= 1; BEATS == 1 SHALL make vector ops behave as scalar ops.
REQ-017 Bubble SHALL be ctrl = 0, valid = 0, beat = 0, vec = 0.
REQ-018 stall_o SHALL be combinational: valid_e & vec_e & (beat_e != BEATS-1).
REQ-019 last_beat_e SHALL be combinational: valid_e & (!vec_e | beat_e == BEATS-1).
REQ-020 E update priority each cycle: reset > flush_e > stall_o hold > stall_in bubble > advance.
REQ-021 Advance: E loads ctrl_d, valid_d, vec_d, beat 0; an invalid D loads a bubble.
REQ-022 Hold (stall_o=1, no flush): E keeps ctrl/vec/valid and beat_e increments by 1; D inputs and stall_in are ignored.
REQ-023 flush_e SHALL make E a bubble next cycle regardless of stall_o, discarding remaining beats; the D instruction of that cycle is dropped.
REQ-024 M SHALL always load E's {ctrl, valid, beat} each cycle (one entry per beat); W SHALL always load M's. M and W never stall or flush.
REQ-025 Latency: a scalar op accepted at cycle n appears in E at n+1, M at n+2, W at n+3.
REQ-026 A vector op accepted at n occupies E cycles n+1..n+BEATS with beat_e 0..BEATS-1, stall_o high for n+1..n+BEATS-1; beat k reaches M at n+2+k and W at n+3+k.
REQ-027 Beats already past E when flush_e asserts SHALL complete through W unchanged.
REQ-028 beat counter SHALL never exceed BEATS-1; no wrap occurs because the op leaves E on its last beat.
REQ-029 Back-to-back vector ops SHALL issue with no gap: next op enters E the cycle after the previous op's last beat.

Reset
REQ-030 reset sampled high SHALL clear E, M, W to bubbles next edge; all ctrl/valid/beat outputs 0, stall_o 0, last_beat_e 0.
REQ-031 reset mid-vector-op SHALL abandon remaining beats; the first post-reset cycle accepts D normally.
REQ-032 reset SHALL take priority over flush_e, stall_in and the hold.

Verification
REQ-033 Scalar stream: ctrl_d=0x00A1,0x00A2,0x00A3 valid, vec_d=0 on cycles 1-3 -> ctrl_w 0x00A1,0x00A2,0x00A3 on cycles 4-6, stall_o always 0.
REQ-034 Vector op (defaults, BEATS=4), ctrl_d=0x1234 at cycle 1 -> beat_e 0,1,2,3 cycles 2-5, stall_o high cycles 2-4, last_beat_e cycle 5, valid_w with beat_w 0..3 cycles 4-7.
REQ-035 stall_in at cycle 3 with scalar 0x0055 in D -> E bubble cycle 4, 0x0055 enters E cycle 5 once stall_in drops at cycle 4.
REQ-036 flush_e at cycle 3 during the vector op of REQ-034 -> E bubble cycle 4, stall_o 0 cycle 4, beats 0,1 still reach W cycles 4,5.
REQ-037 reset at cycle 3 during a vector op -> all outputs 0 cycle 4, next valid D op appears in E one cycle after acceptance.
REQ-038 Sweep LPC=VLANES (BEATS=1): vector op behaves as scalar, stall_o never asserts, beat outputs always 0.
